// File: rtl/sm4_mode_engine.sv
// sm4_mode_engine: SM4 cipher with ECB/CBC/CTR chaining and a cached expanded key.
// unroll_p rounds are evaluated per cycle; the 32 round keys persist while key_i is unchanged.
module sm4_mode_engine #(
    parameter int unroll_p = 1
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [127:0] content_i,
    input  logic [127:0] key_i,
    input  logic [127:0] iv_i,
    input  logic [1:0]   mode_i,
    input  logic         decrypt_i,
    input  logic         first_i,
    input  logic         v_i,
    output logic         ready_o,
    output logic [127:0] crypt_o,
    output logic         v_o,
    input  logic         yumi_i
);
    localparam int rounds_lp = 32 / unroll_p;
    localparam logic [4:0] step_lp = 5'(unroll_p);
    localparam logic [4:0] last_lp = 5'((rounds_lp - 1) * unroll_p);
    localparam logic [127:0] key_xor_mask_p = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;
    localparam logic [0:255][7:0] sbox_lp = {
        128'hd690e9fe_cce13db7_16b614c2_28fb2c05, 128'h2b679a76_2abe04c3_aa441326_49860699,
        128'h9c4250f4_91ef987a_33540b43_edcfac62, 128'he4b31ca9_c908e895_80df94fa_758f3fa6,
        128'h4707a7fc_f37317ba_83593c19_e6854fa8, 128'h686b81b2_7164da8b_f8eb0f4b_70569d35,
        128'h1e240e5e_6358d1a2_25227c3b_01217887, 128'hd4004657_9fd32752_4c3602e7_a0c4c89e,
        128'heabf8ad2_40c738b5_a3f7f2ce_f96115a1, 128'he0ae5da4_9b341a55_ad933230_f58cb1e3,
        128'h1df6e22e_8266ca60_c02923ab_0d534e6f, 128'hd5db3745_defd8e2f_03ff6a72_6d6c5b51,
        128'h8d1baf92_bbddbc7f_11d95c41_1f105ad8, 128'h0ac13188_a5cd7bbd_2d74d012_b8e5b4b0,
        128'h8969974a_0c96777e_65b9f109_c56ec684, 128'h18f07dec_3adc4d20_79ee5f3e_d7cb3948};

    if (unroll_p != 1 && unroll_p != 2 && unroll_p != 4 && unroll_p != 8) begin : g_bad_unroll
        $error("unroll_p must be 1, 2, 4 or 8");
    end

    typedef enum logic [2:0] {eIdle, eCheck, eExpand, eCrypt, eFinish, eDone} state_e;

    function automatic logic [31:0] rotl(input logic [31:0] a, input int n);
        return (a << n) | (a >> (32 - n));
    endfunction

    function automatic logic [31:0] tau(input logic [31:0] a);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = sbox_lp[a[8*b +: 8]];
        return r;
    endfunction

    // CK[i] byte j (MSB first) is (4i+j)*7 mod 256
    function automatic logic [31:0] key_aux(input logic [4:0] i);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[31-8*j -: 8] = 8'((4 * int'(i) + j) * 7);
        return r;
    endfunction

    state_e state_q, state_d;
    logic [4:0] cnt_q, cnt_d, idx;
    logic [127:0] key_q, key_d, kst_q, kst_d, x_q, x_d, content_q, content_d;
    logic [127:0] cin_q, cin_d, chain_q, chain_d, crypt_q, crypt_d, chain_sel, res;
    logic [31:0][31:0] rk_q, rk_d;
    logic [31:0] w, t;
    logic [1:0] mode_q, mode_d;
    logic key_valid_q, key_valid_d, hit_q, hit_d, dec_q, dec_d, ready_q, ready_d, v_q, v_d, last;

    assign last = cnt_q == last_lp;
    assign chain_sel = first_i ? iv_i : chain_q;
    assign res = {x_q[31:0], x_q[63:32], x_q[95:64], x_q[127:96]};

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        key_d = key_q;
        key_valid_d = key_valid_q;
        hit_d = hit_q;
        kst_d = kst_q;
        x_d = x_q;
        content_d = content_q;
        cin_d = cin_q;
        chain_d = chain_q;
        mode_d = mode_q;
        dec_d = dec_q;
        crypt_d = crypt_q;
        rk_d = rk_q;
        idx = cnt_q;
        w = '0;
        t = '0;
        case (state_q)
            eIdle: if (v_i) begin
                state_d = eCheck;
                hit_d = key_valid_q && key_i == key_q;
                key_valid_d = key_valid_q && key_i == key_q;
                key_d = key_i;
                content_d = content_i;
                cin_d = chain_sel;
                mode_d = mode_i == 2'd3 ? 2'd0 : mode_i;
                dec_d = decrypt_i && mode_i != 2'd2;
                x_d = mode_i == 2'd2 ? chain_sel
                    : (mode_i == 2'd1 && !decrypt_i) ? content_i ^ chain_sel : content_i;
            end
            eCheck: begin
                state_d = hit_q ? eCrypt : eExpand;
                kst_d = key_q ^ key_xor_mask_p;
            end
            eExpand: begin
                for (int j = 0; j < unroll_p; j++) begin
                    idx = cnt_q + 5'(j);
                    t = tau(kst_d[95:64] ^ kst_d[63:32] ^ kst_d[31:0] ^ key_aux(idx));
                    w = kst_d[127:96] ^ t ^ rotl(t, 13) ^ rotl(t, 23);
                    rk_d[idx] = w;
                    kst_d = {kst_d[95:0], w};
                end
                cnt_d = last ? '0 : cnt_q + step_lp;
                key_valid_d = key_valid_q || last;
                state_d = last ? eCrypt : eExpand;
            end
            eCrypt: begin
                for (int j = 0; j < unroll_p; j++) begin
                    idx = cnt_q + 5'(j);
                    t = tau(x_d[95:64] ^ x_d[63:32] ^ x_d[31:0] ^ rk_q[dec_q ? 5'd31 - idx : idx]);
                    w = x_d[127:96] ^ t ^ rotl(t, 2) ^ rotl(t, 10) ^ rotl(t, 18) ^ rotl(t, 24);
                    x_d = {x_d[95:0], w};
                end
                cnt_d = last ? '0 : cnt_q + step_lp;
                state_d = last ? eFinish : eCrypt;
            end
            eFinish: begin
                crypt_d = mode_q == 2'd2 ? res ^ content_q : (mode_q == 2'd1 && dec_q) ? res ^ cin_q : res;
                chain_d = mode_q == 2'd2 ? cin_q + 128'd1 : mode_q == 2'd1 ? (dec_q ? content_q : res) : chain_q;
                state_d = eDone;
            end
            eDone: state_d = yumi_i ? eIdle : eDone;
            default: state_d = eIdle;
        endcase
        ready_d = state_d == eIdle;
        v_d = state_d == eDone;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= eIdle;
            cnt_q <= '0;
            key_q <= '0;
            key_valid_q <= 1'b0;
            hit_q <= 1'b0;
            kst_q <= '0;
            x_q <= '0;
            content_q <= '0;
            cin_q <= '0;
            chain_q <= '0;
            mode_q <= '0;
            dec_q <= 1'b0;
            crypt_q <= '0;
            rk_q <= '0;
            ready_q <= 1'b1;
            v_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            key_q <= key_d;
            key_valid_q <= key_valid_d;
            hit_q <= hit_d;
            kst_q <= kst_d;
            x_q <= x_d;
            content_q <= content_d;
            cin_q <= cin_d;
            chain_q <= chain_d;
            mode_q <= mode_d;
            dec_q <= dec_d;
            crypt_q <= crypt_d;
            rk_q <= rk_d;
            ready_q <= ready_d;
            v_q <= v_d;
        end
    end

    assign ready_o = ready_q;
    assign v_o = v_q;
    assign crypt_o = crypt_q;
endmodule

// File: tb/tb_sm4_mode_engine.sv
// tb_sm4_mode_engine: directed known-answer and chaining tests across unroll_p = 1, 2, 4, 8.
module tb_sm4_mode_engine;
    localparam logic [127:0] std_c = 128'h01234567_89abcdef_fedcba98_76543210;
    localparam logic [127:0] cstd_c = 128'h681edf34_d206965e_86b3e94f_536e4246;
    localparam logic [127:0] pat_c = 128'hdeadbeef_00112233_cafef00d_55aa55aa;
    localparam logic [127:0] fk_c = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;
    localparam logic [0:255][7:0] sb_c = {
        128'hd690e9fe_cce13db7_16b614c2_28fb2c05, 128'h2b679a76_2abe04c3_aa441326_49860699,
        128'h9c4250f4_91ef987a_33540b43_edcfac62, 128'he4b31ca9_c908e895_80df94fa_758f3fa6,
        128'h4707a7fc_f37317ba_83593c19_e6854fa8, 128'h686b81b2_7164da8b_f8eb0f4b_70569d35,
        128'h1e240e5e_6358d1a2_25227c3b_01217887, 128'hd4004657_9fd32752_4c3602e7_a0c4c89e,
        128'heabf8ad2_40c738b5_a3f7f2ce_f96115a1, 128'he0ae5da4_9b341a55_ad933230_f58cb1e3,
        128'h1df6e22e_8266ca60_c02923ab_0d534e6f, 128'hd5db3745_defd8e2f_03ff6a72_6d6c5b51,
        128'h8d1baf92_bbddbc7f_11d95c41_1f105ad8, 128'h0ac13188_a5cd7bbd_2d74d012_b8e5b4b0,
        128'h8969974a_0c96777e_65b9f109_c56ec684, 128'h18f07dec_3adc4d20_79ee5f3e_d7cb3948};

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic reset_i, decrypt_i, first_i;
    logic [127:0] content_i, key_i, iv_i;
    logic [1:0] mode_i;
    logic [3:0] v_i, yumi_i, ready_o, v_o;
    logic [127:0] crypt_o [4];
    int checks = 0, errors = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sm4_mode_engine #(.unroll_p(1 << g)) u_dut (
            .clk_i(clk_i), .reset_i(reset_i), .content_i(content_i), .key_i(key_i),
            .iv_i(iv_i), .mode_i(mode_i), .decrypt_i(decrypt_i), .first_i(first_i),
            .v_i(v_i[g]), .ready_o(ready_o[g]), .crypt_o(crypt_o[g]), .v_o(v_o[g]),
            .yumi_i(yumi_i[g]));
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rl(input logic [31:0] a, input int n);
        return (a << n) | (a >> (32 - n));
    endfunction

    function automatic logic [31:0] sub4(input logic [31:0] a);
        return {sb_c[a[31:24]], sb_c[a[23:16]], sb_c[a[15:8]], sb_c[a[7:0]]};
    endfunction

    // Reference SM4 encryption, written straight from the published algorithm
    function automatic logic [127:0] ref_enc(input logic [127:0] key, input logic [127:0] blk);
        logic [31:0] k [36];
        logic [31:0] x [36];
        logic [31:0] tt, ck;
        for (int i = 0; i < 4; i++) begin
            k[i] = key[127-32*i -: 32] ^ fk_c[127-32*i -: 32];
            x[i] = blk[127-32*i -: 32];
        end
        for (int i = 0; i < 32; i++) begin
            ck = {8'(28*i), 8'(28*i+7), 8'(28*i+14), 8'(28*i+21)};
            tt = sub4(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
            k[i+4] = k[i] ^ tt ^ rl(tt, 13) ^ rl(tt, 23);
        end
        for (int i = 0; i < 32; i++) begin
            tt = sub4(x[i+1] ^ x[i+2] ^ x[i+3] ^ k[i+4]);
            x[i+4] = x[i] ^ tt ^ rl(tt, 2) ^ rl(tt, 10) ^ rl(tt, 18) ^ rl(tt, 24);
        end
        return {x[35], x[34], x[33], x[32]};
    endfunction

    // Inputs are scrambled right after the accept edge to prove they are captured.
    task automatic send(input int k, input logic [127:0] c, input logic [127:0] key,
                        input logic [127:0] iv, input logic [1:0] m, input logic d, input logic f,
                        output logic [127:0] out, output int lat);
        @(negedge clk_i);
        content_i = c; key_i = key; iv_i = iv; mode_i = m; decrypt_i = d; first_i = f;
        v_i[k] = 1'b1;
        @(posedge clk_i); #1;
        v_i[k] = 1'b0;
        content_i = ~c; key_i = ~key; iv_i = ~iv; mode_i = ~m; decrypt_i = ~d; first_i = ~f;
        lat = 0;
        while (!v_o[k] && lat < 200) begin
            @(posedge clk_i); #1;
            lat++;
        end
        out = crypt_o[k];
        @(negedge clk_i);
        yumi_i[k] = 1'b1;
        @(posedge clk_i); #1;
        yumi_i[k] = 1'b0;
    endtask

    initial begin
        logic [127:0] out, held, ek0;
        int lat, n;
        reset_i = 1'b1; v_i = '0; yumi_i = '0;
        content_i = '0; key_i = '0; iv_i = '0; mode_i = '0; decrypt_i = 1'b0; first_i = 1'b0;
        #12;
        for (int k = 0; k < 4; k++) begin
            check("rst_ready", 128'(ready_o[k]), 128'd1);
            check("rst_v", 128'(v_o[k]), 128'd0);
            check("rst_crypt", crypt_o[k], '0);
        end
        @(negedge clk_i);
        reset_i = 1'b0;

        for (int k = 0; k < 4; k++) begin
            n = 32 >> k;
            send(k, std_c, std_c, '0, 2'd0, 1'b0, 1'b1, out, lat);
            check("ecb_enc", out, cstd_c);
            check("ecb_enc_lat_miss", 128'(lat), 128'(2*n + 2));
            send(k, cstd_c, std_c, '0, 2'd0, 1'b1, 1'b1, out, lat);
            check("ecb_dec", out, std_c);
            check("ecb_dec_lat_hit", 128'(lat), 128'(n + 2));
        end

        ek0 = ref_enc(std_c, '0);
        send(0, std_c, std_c, '0, 2'd1, 1'b0, 1'b1, out, lat);
        check("cbc_enc_c1", out, cstd_c);
        send(0, cstd_c, std_c, pat_c, 2'd1, 1'b0, 1'b0, out, lat);
        check("cbc_enc_c2", out, ek0);
        send(0, cstd_c, std_c, '0, 2'd1, 1'b1, 1'b1, out, lat);
        check("cbc_dec_p1", out, std_c);
        send(0, ek0, std_c, pat_c, 2'd1, 1'b1, 1'b0, out, lat);
        check("cbc_dec_p2", out, cstd_c);

        send(0, '0, std_c, std_c, 2'd2, 1'b1, 1'b1, out, lat);
        check("ctr_b1", out, cstd_c);
        send(0, pat_c, std_c, '0, 2'd2, 1'b0, 1'b0, out, lat);
        check("ctr_b2", out, ref_enc(std_c, std_c + 128'd1) ^ pat_c);
        send(0, '0, std_c, '1, 2'd2, 1'b0, 1'b1, out, lat);
        check("ctr_wrap_b1", out, ref_enc(std_c, '1));
        send(0, '0, std_c, pat_c, 2'd2, 1'b0, 1'b0, out, lat);
        check("ctr_wrap_b2", out, ek0);
        send(0, std_c, std_c, '0, 2'd3, 1'b0, 1'b1, out, lat);
        check("mode3_ecb", out, cstd_c);
        check("mode3_lat_hit", 128'(lat), 128'd34);

        // backpressure: output held while yumi_i stays low, extra v_i ignored
        @(negedge clk_i);
        content_i = std_c; key_i = std_c; mode_i = 2'd0; decrypt_i = 1'b0; first_i = 1'b1;
        v_i[0] = 1'b1;
        @(posedge clk_i); #1;
        v_i[0] = 1'b0;
        check("busy_ready", 128'(ready_o[0]), 128'd0);
        lat = 0;
        while (!v_o[0] && lat < 200) begin
            @(posedge clk_i); #1;
            lat++;
        end
        held = crypt_o[0];
        check("bp_result", held, cstd_c);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            v_i[0] = i == 3;
            content_i = pat_c ^ 128'(i);
            @(posedge clk_i); #1;
            check("bp_crypt_stable", crypt_o[0], held);
            check("bp_v_held", 128'(v_o[0]), 128'd1);
            check("bp_ready_low", 128'(ready_o[0]), 128'd0);
        end
        @(negedge clk_i);
        v_i[0] = 1'b0;
        yumi_i[0] = 1'b1;
        @(posedge clk_i); #1;
        yumi_i[0] = 1'b0;
        check("bp_release_v", 128'(v_o[0]), 128'd0);
        check("bp_release_ready", 128'(ready_o[0]), 128'd1);

        // reset mid-eCrypt, then chaining restarts from zero with a forced re-expansion
        @(negedge clk_i);
        content_i = std_c; key_i = std_c; mode_i = 2'd0; decrypt_i = 1'b0; first_i = 1'b1;
        v_i[0] = 1'b1;
        @(posedge clk_i); #1;
        v_i[0] = 1'b0;
        repeat (10) @(posedge clk_i);
        #2 reset_i = 1'b1;
        #1;
        check("rst_mid_v", 128'(v_o[0]), 128'd0);
        check("rst_mid_ready", 128'(ready_o[0]), 128'd1);
        @(negedge clk_i);
        reset_i = 1'b0;
        send(0, std_c, std_c, pat_c, 2'd1, 1'b0, 1'b0, out, lat);
        check("post_rst_cbc", out, cstd_c);
        check("post_rst_lat_miss", 128'(lat), 128'd66);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sm4_mode_engine.md
# sm4_mode_engine

Parametrised SM4 block-cipher engine with a configurable number of rounds per cycle and on-chip chaining modes. It extends the single-round ECB encryptor with ECB, CBC and CTR operation, a chaining/counter register, and reuse of an expanded key across blocks. It sits between the host stream interface and the `turn_transform` round primitives, and reuses the `sm4_encryptor_pkg` constants (`group_size_p`=128, `word_width_p`=32, `key_xor_mask_p`, `key_aux_p`).

## Interface
- `unroll_p`, default 1: SM4 rounds evaluated per cycle. Legal values are 1, 2, 4, 8; any other value is a compile-time error.
- `rounds_lp`, default 32/`unroll_p`: cycles per key expansion or per cipher pass (local, called N below).
- `clk_i` in 1: single clock.
- `reset_i` in 1: reset, asynchronous and active-high.
- `content_i` in 128: plaintext (encrypt) or ciphertext (decrypt).
- `key_i` in 128: cipher key.
- `iv_i` in 128: CBC IV or CTR initial counter. Used only when `first_i`=1.
- `mode_i` in 2: 0 ECB, 1 CBC, 2 CTR. Value 3 is treated as ECB.
- `decrypt_i` in 1: 1 selects decryption for ECB/CBC. Ignored in CTR.
- `first_i` in 1: first block of a stream. Loads the chain register from `iv_i`.
- `v_i` in 1 / `ready_o` out 1: input handshake. A transfer occurs when both are 1.
- `crypt_o` out 128: result block.
- `v_o` out 1 / `yumi_i` in 1: output handshake. `yumi_i` is only legal while `v_o`=1.

## Operation
- States:
  - `eIdle`: `ready_o`=1. On `v_i`, capture content, key, iv, mode, decrypt and first, then go to `eCheck`.
  - `eCheck`: 1 cycle. Goes to `eCrypt` if `key_valid_r` && `key_i`==`key_r`, otherwise to `eExpand`.
  - `eExpand`: N cycles. Starts from `key_r`^`key_xor_mask_p`. Each cycle performs `unroll_p` chained key rounds using `key_aux_p[i]` and writes rk[i..i+`unroll_p`-1] into a 32×32 flop array. On exit: `key_valid_r`=1, go to `eCrypt`.
  - `eCrypt`: N cycles. Each cycle performs `unroll_p` chained rounds. The round-key index i is used directly, or 31-i when decrypting in ECB/CBC.
  - `eFinish`: 1 cycle. Word-reverse the state, apply the mode post-processing, update the chain register, then go to `eDone`.
  - `eDone`: `v_o`=1. Go to `eIdle` on `yumi_i`.
- Cipher input and output per mode (chain = `iv_i` if `first_i`, else `chain_r`):
  - ECB: in = content; out = E/D(content).
  - CBC encrypt: in = content^chain; out = C; `chain_r` ← C.
  - CBC decrypt: in = content; out = D(content)^chain; `chain_r` ← content.
  - CTR: always encrypts; in = chain; out = E(chain)^content; `chain_r` ← chain+1, modulo 2^128 (full 128-bit wrap).
- `chain_r` and `key_r`/`key_valid_r` persist across blocks. A new `key_i` value forces re-expansion. A miss that reloads `key_r` overwrites all 32 round keys.
- `mode_i`/`decrypt_i` may change between blocks without re-expansion.

## Timing
- Reset values: state `eIdle`, `ready_o`=1, `v_o`=0, `crypt_o`=0, `key_valid_r`=0, `chain_r`=0, round counter 0.
- Latency from the accept edge to `v_o` rising:
  - Key hit: N+2 edges (34 at `unroll_p`=1, 6 at `unroll_p`=8).
  - Key miss: 2N+2 edges.
- Initiation interval: one block in flight. `ready_o`=0 from the accept edge until the edge after `yumi_i`. Earliest next accept is the cycle after `eDone` exits; there is no bypass from `eDone` to `eIdle`.
- `crypt_o` is registered and held stable throughout `eDone` regardless of how long `yumi_i` stays low. Inputs are don't-care outside the accept cycle.
- Round counter width is $clog2(32); it increments by `unroll_p` and clears on leaving `eExpand`/`eCrypt`.
- Reset asserted in any state:
  - Immediate return to `eIdle`.
  - In-flight block discarded, `v_o` drops asynchronously.
  - Key is invalidated, so the next block always re-expands.
  - `first_i`=0 after reset chains from 0.

## Test plan
- ECB encrypt, key = content = 0123456789abcdeffedcba9876543210, `unroll_p`∈{1,2,4,8} -> `crypt_o`=681edf34d206965e86b3e94f536e4246; `v_o` at 2N+2 edges (miss).
- Same key, ECB decrypt of 681edf34d206965e86b3e94f536e4246 -> 0123456789abcdeffedcba9876543210; `v_o` at N+2 edges (hit, no `eExpand` entry).
- CBC encrypt with the standard key, IV=0, P1=standard plaintext -> C1=681edf34…4246. Then `first_i`=0, P2=C1 -> C2 = E_K(0), matching the reference model. CBC decrypt of C1,C2 with IV=0 -> P1,P2.
- CTR with the standard key, iv = standard plaintext, P=0 -> 681edf34…4246. The next block equals E_K(…3211). With iv=ffff…ffff, the second block equals E_K(0), verifying the 128-bit wrap.
- Backpressure: hold `yumi_i`=0 for 10 cycles in `eDone` -> `crypt_o` and `v_o` stable, `ready_o`=0, and a `v_i` pulse is not accepted.
- Assert `reset_i` mid-`eCrypt` -> `v_o`=0 and `ready_o`=1 immediately. The next block with the same key takes 2N+2 edges and gives the correct result.
